// File: rtl/baud_cfg_ctrl_if.sv
// Request/drain/brg-control bundle between a rate requester,
// the TX/RX paths and the baud configuration controller.
interface baud_cfg_ctrl_if;
  logic       cfg_valid;
  logic [1:0] cfg_sel;
  logic       cfg_ready;
  logic       tx_busy;
  logic       rx_busy;
  logic       hold;
  logic [1:0] brg_select;
  logic       brg_rst_n;
  logic       cfg_done;
  logic       cfg_err;

  modport master (
    output cfg_valid,
    output cfg_sel,
    output tx_busy,
    output rx_busy,
    input  cfg_ready,
    input  hold,
    input  brg_select,
    input  brg_rst_n,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sel,
    input  tx_busy,
    input  rx_busy,
    output cfg_ready,
    output hold,
    output brg_select,
    output brg_rst_n,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/baud_cfg_ctrl.sv
// Run-time baud select controller: drains TX/RX, restarts brg
// with the new select, settles, then reports done or drain timeout.
module baud_cfg_ctrl #(
  parameter int CLK_FREQ      = 576_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input logic            clk,
  input logic            rst,
  baud_cfg_ctrl_if.slave cfg
);

  localparam int DW = (DRAIN_TIMEOUT > 0) ?
                      $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;
  localparam bit TO_EN = (DRAIN_TIMEOUT != 0);
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  if (SETTLE_CYCLES < 1 || CLK_FREQ <= 0) begin : g_bad_param
    $error("baud_cfg_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    APPLY,
    SETTLE,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    pend_sel_q, pend_sel_d;
  logic          err_flag_q, err_flag_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;

  logic          cfg_ready_q, cfg_ready_d;
  logic          hold_q, hold_d;
  logic [1:0]    brg_select_q, brg_select_d;
  logic          brg_rst_n_q, brg_rst_n_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_err_q, cfg_err_d;

  always_comb begin
    state_d      = state_q;
    pend_sel_d   = pend_sel_q;
    err_flag_d   = err_flag_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cfg.cfg_valid && cfg_ready_q) begin
          pend_sel_d  = cfg.cfg_sel;
          err_flag_d  = 1'b0;
          drain_cnt_d = '0;
          state_d     = (cfg.cfg_sel == brg_select_q) ?
                        DONE : DRAIN;
        end
      end
      DRAIN: begin
        // Both paths idle beats a coincident timeout.
        if (!cfg.tx_busy && !cfg.rx_busy) begin
          state_d = APPLY;
        end else if (TO_EN && drain_cnt_q == DRAIN_LAST) begin
          state_d    = DONE;
          err_flag_d = 1'b1;
        end else if (drain_cnt_q != '1) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      APPLY: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = DONE;
        end else if (settle_cnt_q != '1) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered images of the state being entered.
  always_comb begin
    cfg_ready_d  = (state_d == IDLE);
    hold_d       = (state_d == DRAIN) ||
                   (state_d == APPLY) ||
                   (state_d == SETTLE);
    brg_rst_n_d  = (state_d != APPLY);
    brg_select_d = (state_d == APPLY) ?
                   pend_sel_q : brg_select_q;
    cfg_done_d   = (state_d == DONE) && !err_flag_d;
    cfg_err_d    = (state_d == DONE) && err_flag_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_sel_q   <= 2'b00;
      err_flag_q   <= 1'b0;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      cfg_ready_q  <= 1'b0;
      hold_q       <= 1'b0;
      brg_select_q <= 2'b00;
      brg_rst_n_q  <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_sel_q   <= pend_sel_d;
      err_flag_q   <= err_flag_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cfg_ready_q  <= cfg_ready_d;
      hold_q       <= hold_d;
      brg_select_q <= brg_select_d;
      brg_rst_n_q  <= brg_rst_n_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg.cfg_ready  = cfg_ready_q;
  assign cfg.hold       = hold_q;
  assign cfg.brg_select = brg_select_q;
  assign cfg.brg_rst_n  = brg_rst_n_q;
  assign cfg.cfg_done   = cfg_done_q;
  assign cfg.cfg_err    = cfg_err_q;

endmodule
